// File: rtl/fb_mem_init.sv
// Framebuffer clear engine: fills NUM_WORDS words from BASE_ADDR with FILL_PATTERN over Avalon-MM.
// Define FB_MEM_INIT_VERIFY_EN to add a read-back verify pass with sticky error capture.
`timescale 1ns/1ps
module fb_mem_init #(
  parameter int                      ADDR_WIDTH   = 25,
  parameter int                      DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR    = '0,
  parameter int                      NUM_WORDS    = 614400,
  parameter logic [DATA_WIDTH-1:0]   FILL_PATTERN = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] avl_addr,
  output logic                  avl_write,
  output logic [DATA_WIDTH-1:0] avl_wdata,
  input  logic                  avl_waitrequest,
`ifdef FB_MEM_INIT_VERIFY_EN
  output logic                  avl_read,
  input  logic [DATA_WIDTH-1:0] avl_readdata,
  input  logic                  avl_readdatavalid,
  output logic                  verify_err,
  output logic [ADDR_WIDTH-1:0] verify_err_addr,
`endif
  output logic                  busy,
  output logic                  mem_init_done
);

  localparam int                   CNT_WIDTH = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_IDX  = CNT_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_WRITE,
`ifdef FB_MEM_INIT_VERIFY_EN
    S_READ,
    S_RD_WAIT,
`endif
    S_DONE
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic                  r_done;

  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  w_write_nxt;
  logic                  w_done_nxt;

`ifdef FB_MEM_INIT_VERIFY_EN
  logic                  r_read;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_err_addr;
  logic                  w_read_nxt;
  logic                  w_err_nxt;
  logic [ADDR_WIDTH-1:0] w_err_addr_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_write_nxt = r_write;
    w_done_nxt  = r_done;
`ifdef FB_MEM_INIT_VERIFY_EN
    w_read_nxt     = r_read;
    w_err_nxt      = r_err;
    w_err_addr_nxt = r_err_addr;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_WAIT_RDY;
          w_done_nxt  = 1'b0;
`ifdef FB_MEM_INIT_VERIFY_EN
          w_err_nxt      = 1'b0;
          w_err_addr_nxt = '0;
`endif
        end
      end

      S_WAIT_RDY: begin
        w_cnt_nxt  = '0;
        w_addr_nxt = BASE_ADDR;
        if (mem_ready) begin
          w_state_nxt = S_WRITE;
          w_write_nxt = 1'b1;
        end
      end

      // Once writing, mem_ready is ignored; only waitrequest stalls the request.
      S_WRITE: begin
        if (!avl_waitrequest) begin
          if (r_cnt != LAST_IDX) begin
            w_cnt_nxt  = r_cnt + CNT_WIDTH'(1);
            w_addr_nxt = r_addr + ADDR_WIDTH'(1);
          end else begin
            w_write_nxt = 1'b0;
`ifdef FB_MEM_INIT_VERIFY_EN
            w_state_nxt = S_READ;
            w_read_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_addr_nxt  = BASE_ADDR;
`else
            w_state_nxt = S_DONE;
`endif
          end
        end
      end

`ifdef FB_MEM_INIT_VERIFY_EN
      S_READ: begin
        if (!avl_waitrequest) begin
          w_read_nxt  = 1'b0;
          w_state_nxt = S_RD_WAIT;
        end
      end

      // Only the first failing address is kept; the pass always runs to the last word.
      S_RD_WAIT: begin
        if (avl_readdatavalid) begin
          if ((avl_readdata != FILL_PATTERN) && !r_err) begin
            w_err_nxt      = 1'b1;
            w_err_addr_nxt = r_addr;
          end
          if (r_cnt != LAST_IDX) begin
            w_cnt_nxt   = r_cnt + CNT_WIDTH'(1);
            w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
            w_read_nxt  = 1'b1;
            w_state_nxt = S_READ;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
`endif

      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_WAIT_RDY;
        w_write_nxt = 1'b0;
      end
    endcase
  end

  // Reset lands in S_WAIT_RDY so the first clear starts without a start pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_WAIT_RDY;
      r_cnt   <= '0;
      r_addr  <= BASE_ADDR;
      r_write <= 1'b0;
      r_done  <= 1'b0;
`ifdef FB_MEM_INIT_VERIFY_EN
      r_read     <= 1'b0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_write <= w_write_nxt;
      r_done  <= w_done_nxt;
`ifdef FB_MEM_INIT_VERIFY_EN
      r_read     <= w_read_nxt;
      r_err      <= w_err_nxt;
      r_err_addr <= w_err_addr_nxt;
`endif
    end
  end

  assign avl_addr      = r_addr;
  assign avl_write     = r_write;
  assign avl_wdata     = FILL_PATTERN;
  assign busy          = (r_state != S_IDLE);
  assign mem_init_done = r_done;

`ifdef FB_MEM_INIT_VERIFY_EN
  assign avl_read        = r_read;
  assign verify_err      = r_err;
  assign verify_err_addr = r_err_addr;
`endif

endmodule

// File: tb/tb_fb_mem_init.sv
// Self-checking bench for fb_mem_init: two instances (6 words wrapping the 8-bit address space,
// and a single-word clear) share randomized stimulus and are checked against a word-count model.
`timescale 1ns/1ps
module tb_fb_mem_init;

  localparam int             AW     = 8;
  localparam int             DW     = 32;
  localparam logic [DW-1:0]  FILL   = 32'hA5C3_0F96;
  localparam logic [AW-1:0]  BASE0  = 8'hFD;
  localparam int             WORDS0 = 6;
  localparam logic [AW-1:0]  BASE1  = 8'h40;
  localparam int             WORDS1 = 1;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic start    = 1'b0;
  logic memReady = 1'b0;
  logic waitReq  = 1'b0;

  logic [AW-1:0] addr0, addr1;
  logic          write0, write1;
  logic [DW-1:0] wdata0, wdata1;
  logic          busy0, busy1;
  logic          done0, done1;

  int checkCount = 0;
  int passCount  = 0;

  // Model per instance: a clear is in progress, mem_ready has been seen, words accepted so far.
  bit mClearing  [2] = '{1'b1, 1'b1};
  bit mReadySeen [2] = '{1'b0, 1'b0};
  int mAccepted  [2] = '{0, 0};
  bit mDone      [2] = '{1'b0, 1'b0};

  fb_mem_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE0),
    .NUM_WORDS(WORDS0), .FILL_PATTERN(FILL)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start), .mem_ready(memReady),
    .avl_addr(addr0), .avl_write(write0), .avl_wdata(wdata0),
    .avl_waitrequest(waitReq), .busy(busy0), .mem_init_done(done0)
  );

  fb_mem_init #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE1),
    .NUM_WORDS(WORDS1), .FILL_PATTERN(FILL)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start), .mem_ready(memReady),
    .avl_addr(addr1), .avl_write(write1), .avl_wdata(wdata1),
    .avl_waitrequest(waitReq), .busy(busy1), .mem_init_done(done1)
  );

  always #5 clk = ~clk;

  function automatic int wordsOf(input int k);
    return (k == 0) ? WORDS0 : WORDS1;
  endfunction

  function automatic logic [AW-1:0] baseOf(input int k);
    return (k == 0) ? BASE0 : BASE1;
  endfunction

  // Reference model: a clear waits for mem_ready, then takes one word per unstalled cycle
  // while words remain; one cycle after the last word it reports done and goes idle.
  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        mClearing[k]  <= 1'b1;
        mReadySeen[k] <= 1'b0;
        mAccepted[k]  <= 0;
        mDone[k]      <= 1'b0;
      end else if (mClearing[k]) begin
        if (!mReadySeen[k]) begin
          if (memReady) mReadySeen[k] <= 1'b1;
        end else if (mAccepted[k] < wordsOf(k)) begin
          if (!waitReq) mAccepted[k] <= mAccepted[k] + 1;
        end else begin
          mClearing[k] <= 1'b0;
          mDone[k]     <= 1'b1;
        end
      end else if (start) begin
        mClearing[k]  <= 1'b1;
        mReadySeen[k] <= 1'b0;
        mAccepted[k]  <= 0;
        mDone[k]      <= 1'b0;
      end
    end
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    else
      passCount++;
  endtask

  // Compares both instances against the model's view of the current cycle.
  task automatic compareModel();
    for (int k = 0; k < 2; k++) begin
      logic          expWrite;
      logic [AW-1:0] expAddr;
      expWrite = mClearing[k] && mReadySeen[k] && (mAccepted[k] < wordsOf(k));
      expAddr  = baseOf(k) + AW'(mAccepted[k]);
      checkOutput($sformatf("busy%0d", k),  (k == 0) ? busy0 : busy1,   mClearing[k]);
      checkOutput($sformatf("done%0d", k),  (k == 0) ? done0 : done1,   mDone[k]);
      checkOutput($sformatf("write%0d", k), (k == 0) ? write0 : write1, expWrite);
      if (expWrite)
        checkOutput($sformatf("addr%0d", k), (k == 0) ? addr0 : addr1, expAddr);
      checkOutput($sformatf("wdata%0d", k), (k == 0) ? wdata0 : wdata1, FILL);
    end
  endtask

  // Samples on the falling edge, then drives the inputs for the next rising edge.
  task automatic applyStimulus(input bit st, input bit mr, input bit wr);
    @(negedge clk);
    compareModel();
    start    = st;
    memReady = mr;
    waitReq  = wr;
  endtask

  // Mid-cycle reset: outputs must drop before any clock edge arrives.
  task automatic resetPulse();
    @(negedge clk);
    compareModel();
    #2 reset = 1'b0;
    #1;
    checkOutput("rstWrite0", write0, 1'b0);
    checkOutput("rstWrite1", write1, 1'b0);
    checkOutput("rstBusy0",  busy0,  1'b1);
    checkOutput("rstBusy1",  busy1,  1'b1);
    checkOutput("rstDone0",  done0,  1'b0);
    checkOutput("rstDone1",  done1,  1'b0);
    checkOutput("rstAddr0",  addr0,  BASE0);
    checkOutput("rstAddr1",  addr1,  BASE1);
    @(negedge clk);
    compareModel();
    reset = 1'b1;
  endtask

  initial begin
    int  lat  [2];
    bit  seen [2];

    #1 reset = 1'b0;
    #1;
    checkOutput("initWrite0", write0, 1'b0);
    checkOutput("initBusy0",  busy0,  1'b1);
    checkOutput("initDone0",  done0,  1'b0);
    checkOutput("initAddr0",  addr0,  BASE0);
    checkOutput("initAddr1",  addr1,  BASE1);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // Memory not ready for 50 cycles, then no stalls: measure cycles to done.
    repeat (50) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    lat  = '{0, 0};
    seen = '{1'b0, 1'b0};
    for (int c = 1; c <= 40; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (!seen[0] && done0) begin seen[0] = 1'b1; lat[0] = c; end
      if (!seen[1] && done1) begin seen[1] = 1'b1; lat[1] = c; end
    end
    checkOutput("latency0", lat[0], WORDS0 + 2);
    checkOutput("latency1", lat[1], WORDS1 + 2);

    // Restart with a 3-cycle stall on the third word and a start pulse while busy.
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int c = 1; c <= 20; c++)
      applyStimulus(c == 2, 1'b1, (c >= 4) && (c <= 6));

    // Restart and hit reset once the second word has been accepted.
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int c = 0; (c < 30) && (mAccepted[0] < 2); c++)
      applyStimulus(1'b0, 1'b1, 1'b0);
    resetPulse();
    repeat (15) applyStimulus(1'b0, 1'b1, 1'b0);

    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0)
        resetPulse();
      else
        applyStimulus($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) == 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
